offchip_mem_arbiter: RTL and testbench
======================================

# offchip_mem_arbiter

Shares the single off-chip memory port of `cpu_pipeline` between the instruction cache (line fills) and the data cache (line fills and write-backs). Accepts level requests from both caches, grants one at a time with round-robin priority, drives the cache-line-wide off-chip read/write enables, and returns data and a one-cycle acknowledge. Sits between the cache pair and the top-level `offchip_mem_*` pins.

## Interface
- `LINE_BYTES`, default `` `CACHE_LINE_SIZE `` (16): cache line size in bytes; data width is `LINE_BYTES*8`.
- `ADDR_WIDTH`, default 32: byte address width.
- `TIMEOUT_CYCLES`, default 1024: max cycles waiting for `offchip_mem_ready`; 0 disables timeout.

- `clk`  in  1  core clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `ic_req`  in  1  icache line-read request, held until `ic_ack`.
- `ic_addr`  in  ADDR_WIDTH  icache line address.
- `ic_ack`  out  1  one-cycle completion pulse to icache.
- `dc_req`  in  1  dcache request, held until `dc_ack`.
- `dc_we`  in  1  1 = line write-back, 0 = line fill.
- `dc_addr`  in  ADDR_WIDTH  dcache line address.
- `dc_wdata`  in  LINE_BYTES*8  write-back line.
- `dc_ack`  out  1  one-cycle completion pulse to dcache.
- `rsp_rdata`  out  LINE_BYTES*8  read line, valid in ack cycle, held until next read completes.
- `rsp_err`  out  1  1 in ack cycle if the transaction timed out.
- `offchip_mem_addr`  out  32  line address to memory.
- `offchip_mem_wdata`  out  LINE_BYTES*8  write line.
- `offchip_mem_read_en`  out  1  read enable, level.
- `offchip_mem_write_en`  out  1  write enable, level.
- `offchip_mem_data`  in  LINE_BYTES*8  read line from memory.
- `offchip_mem_ready`  in  1  completion; may stay high for several cycles.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any req, pick winner, latch addr/we/wdata, set enable, -> BUSY. Read enable for icache and dcache fills, write enable for dcache write-back; never both.
- Arbitration: round-robin pointer `last_dc`; on simultaneous requests the requester not granted last wins. After reset dcache wins the first tie.
- BUSY: timeout counter increments each cycle. On first cycle with `offchip_mem_ready`=1: capture `offchip_mem_data` into `rsp_rdata` (reads only), pulse winner's ack, drop enables, -> RELEASE. If counter reaches TIMEOUT_CYCLES first: pulse ack with `rsp_err`=1, `rsp_rdata` unchanged, drop enables, -> RELEASE.
- RELEASE: wait until `offchip_mem_ready`=0, then -> IDLE. Prevents a multi-cycle ready from completing the next transaction.
- Requests dropped during BUSY are ignored; transaction completes and ack still pulses. Requesters must not drop req before ack.
- Address/wdata outputs hold latched values from grant until next grant.
- Late ready after a timeout is unsupported (system fatal).

## Timing
- Reset (async, `rst`=0): state IDLE, all outputs 0, pointer to dcache-priority, counter 0. Reset mid-transaction abandons it; no ack.
- All outputs registered. Req seen in IDLE at cycle N -> enable high from cycle N+1.
- Ready first high at cycle M (sampled) -> ack/`rsp_rdata` valid and enable low at cycle M+1.
- Minimum turnaround: next grant sampled in the first cycle that RELEASE sees ready low. If ready is already low in the ack cycle, that is at M+1; enable rises at M+2.
- Ack never asserted on two consecutive cycles; `ic_ack` and `dc_ack` never simultaneous.

## Structure
- Shared package/header (`config.v`): `CACHE_LINE_SIZE`, state encodings (`ARB_IDLE`, `ARB_BUSY`, `ARB_RELEASE`), default timeout.
- Single module; no sub-module needed. Round-robin select is inline logic.

## Test plan
- Icache only, addr 0x40, memory returns line 0x0F..0x00, ready high 5 cycles -> one read_en window, `ic_ack` 1 cycle, `rsp_rdata` = that line, `rsp_err`=0, no second read.
- Simultaneous `ic_req` + `dc_req` (fill 0x80) right after reset -> dcache served first, icache second; repeat both -> icache first this time.
- Dcache write-back addr 0x100, wdata 0xA5 repeated -> `offchip_mem_write_en` high, read_en low, addr 0x100, wdata matches; `dc_ack` on ready; `rsp_rdata` unchanged.
- Ready held high 5 cycles with a second request pending -> second enable rises only after ready falls.
- TIMEOUT_CYCLES=8, ready never asserted -> ack with `rsp_err`=1 on the 9th BUSY cycle, enables drop.
- `rst` asserted mid-BUSY -> all outputs 0 immediately, no ack; after release a new request completes normally.

Source files
------------

// File: rtl/offchip_mem_arbiter_pkg.sv
// Shared definitions for the off-chip memory arbiter: the default line size,
// the arbiter state encoding and the default ready timeout.
package offchip_mem_arbiter_pkg;

  localparam int CACHE_LINE_SIZE        = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/offchip_mem_arbiter.sv
// Shares the single off-chip memory port between the icache (line fills) and
// the dcache (line fills and write-backs). One transaction is in flight at a
// time; ties are broken round-robin. All outputs come straight from flops.
//
// Handshake: a requester raises req (with addr/we/wdata stable) and holds it
// until its ack pulses for exactly one cycle; it drops req in that ack cycle.
// Toward memory, the read/write enable is a level held until the first cycle
// offchip_mem_ready is sampled high (or the timeout expires); ready may stay
// high afterwards, so the arbiter waits for it to fall before the next grant.
module offchip_mem_arbiter
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES     = CACHE_LINE_SIZE,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_ack,
  input  logic                    dc_req,
  input  logic                    dc_we,
  input  logic [ADDR_WIDTH-1:0]   dc_addr,
  input  logic [LINE_BYTES*8-1:0] dc_wdata,
  output logic                    dc_ack,
  output logic [LINE_BYTES*8-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   offchip_mem_addr,
  output logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic                    offchip_mem_read_en,
  output logic                    offchip_mem_write_en,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_data,
  input  logic                    offchip_mem_ready,
  output arb_state_t              dbg_state
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout disables it.
  localparam int                CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]  CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t       state;
  logic             last_dc;   // 1 when the dcache received the most recent grant
  logic             owner_dc;  // requester owning the in-flight transaction
  logic             cur_we;    // in-flight transaction is a write-back
  logic [CNT_W-1:0] tmo_cnt;

  logic any_req;
  logic pick_dc;
  logic grant_now;
  logic timed_out;

  assign dbg_state = state;

  // Round-robin winner select and grant/timeout conditions.
  always_comb begin
    any_req   = ic_req | dc_req;
    pick_dc   = dc_req & (~ic_req | ~last_dc);
    grant_now = any_req & ((state == ARB_IDLE) |
                           ((state == ARB_RELEASE) & ~offchip_mem_ready));
    timed_out = TIMEOUT_EN & (tmo_cnt == CNT_LAST);
  end

  // Arbiter FSM with all memory-side and cache-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ARB_IDLE;
      last_dc              <= 1'b0;
      owner_dc             <= 1'b0;
      cur_we               <= 1'b0;
      tmo_cnt              <= '0;
      ic_ack               <= 1'b0;
      dc_ack               <= 1'b0;
      rsp_rdata            <= '0;
      rsp_err              <= 1'b0;
      offchip_mem_addr     <= '0;
      offchip_mem_wdata    <= '0;
      offchip_mem_read_en  <= 1'b0;
      offchip_mem_write_en <= 1'b0;
    end else begin
      ic_ack  <= 1'b0;
      dc_ack  <= 1'b0;
      rsp_err <= 1'b0;
      if (grant_now) begin
        // Grant from IDLE, or directly from RELEASE once ready has fallen.
        state    <= ARB_BUSY;
        owner_dc <= pick_dc;
        last_dc  <= pick_dc;
        tmo_cnt  <= '0;
        if (pick_dc) begin
          offchip_mem_addr     <= dc_addr;
          offchip_mem_wdata    <= dc_wdata;
          offchip_mem_read_en  <= ~dc_we;
          offchip_mem_write_en <= dc_we;
          cur_we               <= dc_we;
        end else begin
          offchip_mem_addr     <= ic_addr;
          offchip_mem_wdata    <= '0;
          offchip_mem_read_en  <= 1'b1;
          offchip_mem_write_en <= 1'b0;
          cur_we               <= 1'b0;
        end
      end else begin
        case (state)
          ARB_BUSY: begin
            if (offchip_mem_ready || timed_out) begin
              // Ready wins over a timeout expiring in the same cycle.
              if (offchip_mem_ready && !cur_we) begin
                rsp_rdata <= offchip_mem_data;
              end
              rsp_err              <= ~offchip_mem_ready;
              ic_ack               <= ~owner_dc;
              dc_ack               <= owner_dc;
              offchip_mem_read_en  <= 1'b0;
              offchip_mem_write_en <= 1'b0;
              state                <= ARB_RELEASE;
            end else if (TIMEOUT_EN) begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          ARB_RELEASE: begin
            if (!offchip_mem_ready) begin
              state <= ARB_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Directed bench for offchip_mem_arbiter: a transaction-level expected queue
// checked every cycle, a simple memory responder, and literal timing checks.
module tb_offchip_mem_arbiter;
  import offchip_mem_arbiter_pkg::*;

  localparam int DW = 128;
  localparam int AW = 32;

  typedef struct {
    logic          is_dc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] line;
  } txn_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ack;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_ack;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  arb_state_t    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  offchip_mem_arbiter #(.LINE_BYTES(16), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ic_req               (ic_req),
    .ic_addr              (ic_addr),
    .ic_ack               (ic_ack),
    .dc_req               (dc_req),
    .dc_we                (dc_we),
    .dc_addr              (dc_addr),
    .dc_wdata             (dc_wdata),
    .dc_ack               (dc_ack),
    .rsp_rdata            (rsp_rdata),
    .rsp_err              (rsp_err),
    .offchip_mem_addr     (mem_addr),
    .offchip_mem_wdata    (mem_wdata),
    .offchip_mem_read_en  (mem_read_en),
    .offchip_mem_write_en (mem_write_en),
    .offchip_mem_data     (mem_data),
    .offchip_mem_ready    (mem_ready),
    .dbg_state            (dbg_state)
  );

  // ---------------- bench state ----------------
  int            checks;
  int            errors;
  int            cyc;
  txn_t          exp_q[$];
  logic [DW-1:0] model_rdata;
  logic          prev_en;
  logic          prev_ack;
  int            en_len;
  int            rise_hist[$];
  int            ack_hist[$];
  int            len_hist[$];
  // memory responder knobs
  logic          mem_auto;
  int            mem_delay;
  int            mem_hold;
  logic [DW-1:0] mem_line;
  int            en_cnt;
  int            hold_left;
  // dcache re-request on ack
  logic          dc_rearm;
  logic [AW-1:0] rearm_addr;
  int            req_cyc;

  localparam logic [DW-1:0] LINE_T1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [DW-1:0] LINE_T2 = 128'h11111111_22223333_44445555_66667777;
  localparam logic [DW-1:0] LINE_T4 = 128'h2222CAFE_0000BEEF_12345678_9ABCDEF0;
  localparam logic [DW-1:0] LINE_T6 = 128'h33333333_33333333_33333333_33333333;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int hist_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic push_txn(input logic is_dc, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic err, input logic [DW-1:0] line);
    txn_t t;
    t.is_dc = is_dc; t.we = we; t.addr = addr; t.wdata = wdata; t.err = err; t.line = line;
    exp_q.push_back(t);
  endtask

  task automatic clear_hist();
    rise_hist.delete();
    ack_hist.delete();
    len_hist.delete();
  endtask

  // ---------------- scoreboard compare, once per cycle ----------------
  task automatic monitor();
    txn_t t;
    logic en;
    logic ack;
    en  = mem_read_en | mem_write_en;
    ack = ic_ack | dc_ack;
    check("one_enable", DW'(mem_read_en & mem_write_en), '0);
    check("one_ack", DW'(ic_ack & dc_ack), '0);
    if (en && !prev_en) begin
      rise_hist.push_back(cyc);
      en_len = 0;
    end
    if (en) begin
      en_len++;
      check("txn_pending_for_enable", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        t = exp_q[0];
        check("mem_addr", DW'(mem_addr), DW'(t.addr));
        check("mem_wdata", mem_wdata, t.wdata);
        check("mem_write_en", DW'(mem_write_en), DW'(t.we));
        check("mem_read_en", DW'(mem_read_en), DW'(!t.we));
      end
    end
    if (ack) begin
      check("ack_not_back_to_back", DW'(prev_ack), '0);
      check("enable_low_at_ack", DW'(en), '0);
      check("txn_pending_for_ack", DW'(exp_q.size() != 0), DW'(1));
      ack_hist.push_back(cyc);
      len_hist.push_back(en_len);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check("ic_ack", DW'(ic_ack), DW'(!t.is_dc));
        check("dc_ack", DW'(dc_ack), DW'(t.is_dc));
        check("rsp_err", DW'(rsp_err), DW'(t.err));
        if (!t.we && !t.err) model_rdata = t.line;
      end
    end else begin
      check("rsp_err_idle", DW'(rsp_err), '0);
    end
    check("rsp_rdata", rsp_rdata, model_rdata);
    prev_en  = en;
    prev_ack = ack;
  endtask

  // ---------------- one clock: requesters, memory, compare ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (ic_ack) ic_req = 1'b0;
    if (dc_ack) begin
      if (dc_rearm) begin
        dc_addr  = rearm_addr;
        dc_rearm = 1'b0;
      end else begin
        dc_req = 1'b0;
      end
    end
    if (mem_ready) begin
      hold_left--;
      if (hold_left <= 0) mem_ready = 1'b0;
    end
    if (!rst) begin
      mem_ready = 1'b0;
      en_cnt    = 0;
    end else if (mem_read_en || mem_write_en) begin
      en_cnt++;
      if (mem_auto && en_cnt == mem_delay) begin
        mem_ready = 1'b1;
        hold_left = mem_hold;
        mem_data  = mem_line;
      end
    end else begin
      en_cnt = 0;
    end
    @(negedge clk);
    if (rst) monitor();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ic_req || dc_req || mem_ready) && n < budget) begin
      step();
      n++;
    end
    check("drained_in_budget", DW'(exp_q.size() != 0 || ic_req || dc_req), '0);
    repeat (3) step();
    check("back_to_idle", DW'(dbg_state), DW'(ARB_IDLE));
  endtask

  task automatic clear_model();
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_rearm = 1'b0;
    exp_q.delete();
    model_rdata = '0;
    prev_en = 1'b0;
    prev_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ic_ack"}, DW'(ic_ack), '0);
    check({tag, "_dc_ack"}, DW'(dc_ack), '0);
    check({tag, "_rsp_rdata"}, rsp_rdata, '0);
    check({tag, "_rsp_err"}, DW'(rsp_err), '0);
    check({tag, "_mem_addr"}, DW'(mem_addr), '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_read_en"}, DW'(mem_read_en), '0);
    check({tag, "_write_en"}, DW'(mem_write_en), '0);
    check({tag, "_state"}, DW'(dbg_state), DW'(ARB_IDLE));
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_model();
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b0;
    ic_addr = '0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 1'b0; mem_data = '0; mem_auto = 1'b1;
    mem_delay = 1; mem_hold = 1; mem_line = '0;
    en_cnt = 0; hold_left = 0; rearm_addr = '0; req_cyc = 0; en_len = 0;
    clear_model();

    // Reset values
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    step();
    step();

    // T1: icache read 0x40, ready held 5 cycles, memory answers on 2nd enable cycle
    clear_hist();
    mem_delay = 2; mem_hold = 5; mem_line = LINE_T1;
    push_txn(1'b0, 1'b0, 32'h40, '0, 1'b0, LINE_T1);
    ic_addr = 32'h40; ic_req = 1'b1; req_cyc = cyc;
    run_until_idle(100);
    repeat (6) step();
    check("t1_single_window", DW'(rise_hist.size()), DW'(1));
    check("t1_req_to_enable", DW'(hist_at(rise_hist, 0) - req_cyc), DW'(1));
    check("t1_window_len", DW'(hist_at(len_hist, 0)), DW'(2));
    check("t1_rise_to_ack", DW'(hist_at(ack_hist, 0) - hist_at(rise_hist, 0)), DW'(2));
    check("t1_rdata", rsp_rdata, LINE_T1);

    // T2: tie right after reset -> dcache first; dcache re-requests in its ack
    // cycle, so the next tie goes to the icache, then dcache again.
    reset_dut();
    clear_hist();
    mem_delay = 1; mem_hold = 1; mem_line = LINE_T2;
    dc_we = 1'b0; dc_addr = 32'h80; dc_wdata = 128'hDEAD;
    ic_addr = 32'h140;
    dc_rearm = 1'b1; rearm_addr = 32'h180;
    push_txn(1'b1, 1'b0, 32'h80, 128'hDEAD, 1'b0, LINE_T2);
    push_txn(1'b0, 1'b0, 32'h140, '0, 1'b0, LINE_T2);
    push_txn(1'b1, 1'b0, 32'h180, 128'hDEAD, 1'b0, LINE_T2);
    ic_req = 1'b1; dc_req = 1'b1;
    run_until_idle(100);
    check("t2_windows", DW'(rise_hist.size()), DW'(3));
    check("t2_turnaround_1", DW'(hist_at(rise_hist, 1) - hist_at(ack_hist, 0)), DW'(1));
    check("t2_turnaround_2", DW'(hist_at(rise_hist, 2) - hist_at(ack_hist, 1)), DW'(1));

    // T3: dcache write-back 0x100 with A5 pattern; read data must not change
    clear_hist();
    dc_we = 1'b1; dc_addr = 32'h100; dc_wdata = {16{8'hA5}};
    push_txn(1'b1, 1'b1, 32'h100, {16{8'hA5}}, 1'b0, '0);
    dc_req = 1'b1;
    run_until_idle(100);
    check("t3_windows", DW'(rise_hist.size()), DW'(1));
    check("t3_rdata_kept", rsp_rdata, LINE_T2);

    // T4: ready held 5 cycles while the second request waits (icache wins tie)
    clear_hist();
    mem_delay = 1; mem_hold = 5; mem_line = LINE_T4;
    dc_we = 1'b0; dc_addr = 32'h240; dc_wdata = 128'h5A5A;
    ic_addr = 32'h200;
    push_txn(1'b0, 1'b0, 32'h200, '0, 1'b0, LINE_T4);
    push_txn(1'b1, 1'b0, 32'h240, 128'h5A5A, 1'b0, LINE_T4);
    ic_req = 1'b1; dc_req = 1'b1;
    run_until_idle(100);
    check("t4_windows", DW'(rise_hist.size()), DW'(2));
    check("t4_wait_for_ready_low", DW'(hist_at(rise_hist, 1) - hist_at(ack_hist, 0)), DW'(5));

    // T5: no ready at all -> error ack after 8 enable cycles
    clear_hist();
    mem_auto = 1'b0;
    dc_we = 1'b0; dc_addr = 32'h300; dc_wdata = 128'h77;
    push_txn(1'b1, 1'b0, 32'h300, 128'h77, 1'b1, '0);
    dc_req = 1'b1;
    run_until_idle(100);
    check("t5_window_len", DW'(hist_at(len_hist, 0)), DW'(8));
    check("t5_rise_to_ack", DW'(hist_at(ack_hist, 0) - hist_at(rise_hist, 0)), DW'(8));
    check("t5_rdata_kept", rsp_rdata, LINE_T4);
    mem_auto = 1'b1;

    // T6: reset while BUSY abandons the read; a new request then completes
    clear_hist();
    mem_auto = 1'b0;
    ic_addr = 32'h400;
    push_txn(1'b0, 1'b0, 32'h400, '0, 1'b0, '0);
    ic_req = 1'b1;
    repeat (3) step();
    check("t6_busy_before_reset", DW'(mem_read_en), DW'(1));
    rst = 1'b0;
    #1;
    check_all_zero("t6_reset");
    clear_model();
    step();
    step();
    check("t6_no_ack_in_reset", DW'(ic_ack | dc_ack), '0);
    rst = 1'b1;
    mem_auto = 1'b1; mem_delay = 1; mem_hold = 1; mem_line = LINE_T6;
    clear_hist();
    dc_we = 1'b0; dc_addr = 32'h440; dc_wdata = 128'h99;
    push_txn(1'b1, 1'b0, 32'h440, 128'h99, 1'b0, LINE_T6);
    dc_req = 1'b1;
    run_until_idle(100);
    check("t6_one_ack", DW'(ack_hist.size()), DW'(1));
    check("t6_rdata", rsp_rdata, LINE_T6);

    check("queue_empty_at_end", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
